// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: FPU sequencing states, counter width and the default
// multi-cycle FPU latency used by the hazard, forwarding and FPU blocks.
package hazard_controller_pkg;

    localparam int FPU_LAT_DEFAULT = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FPU_RUN  = 2'd1,
        ST_FPU_DONE = 2'd2
    } fpu_state_e;

    // Launch cycle plus release cycle plus the zero-count RUN cycle account for three of the FPU_LAT cycles.
    function automatic logic [CNT_W-1:0] fpu_run_load(input int lat);
        logic [CNT_W-1:0] v;
        if (lat > 2) begin
            v = CNT_W'(lat - 3);
        end else begin
            v = {CNT_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/hazard_fpu_timer.sv
// Down-counter that times the FPU_RUN phase: load, saturating decrement and zero flag.
module hazard_fpu_timer
    import hazard_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Counter register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle FPU hold,
// with all outputs combinational from the current FSM state and inputs.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int FPU_LAT = FPU_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_Rs1,
    input  logic [4:0] ID_Rs2,
    input  logic [4:0] ID_frs3,
    input  logic       ID_useRs1,
    input  logic       ID_useRs2,
    input  logic       ID_useRs3,
    input  logic       ID_fpRs1,
    input  logic       ID_fpRs2,
    input  logic       EX_MemRead,
    input  logic       EX_RegWrite,
    input  logic       EX_f_RegWrite,
    input  logic [4:0] EX_Rd,
    input  logic       EX_fpu_multi,
    input  logic       branch_taken,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       ID_EX_bubble,
    output logic       IF_ID_flush,
    output logic       EX_hold,
    output logic       fpu_start,
    output logic       fpu_busy
);

    localparam logic [CNT_W-1:0] C_RUN_LOAD = fpu_run_load(FPU_LAT);
    localparam bit               C_HAS_RUN  = (FPU_LAT > 2);

    fpu_state_e r_state;
    fpu_state_e w_next_state;

    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_zero;
    logic w_fsm_start;
    logic w_fsm_hold;
    logic w_fsm_busy;

    logic w_int_wr_ok;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rs3_hit;
    logic w_load_use;

    // x0 is hardwired so it never creates a dependency; f0 is an ordinary FP register.
    assign w_int_wr_ok = EX_RegWrite && (EX_Rd != 5'd0);
    assign w_rs1_hit   = ID_useRs1 && (EX_Rd == ID_Rs1)  && (ID_fpRs1 ? EX_f_RegWrite : w_int_wr_ok);
    assign w_rs2_hit   = ID_useRs2 && (EX_Rd == ID_Rs2)  && (ID_fpRs2 ? EX_f_RegWrite : w_int_wr_ok);
    assign w_rs3_hit   = ID_useRs3 && (EX_Rd == ID_frs3) && EX_f_RegWrite;
    assign w_load_use  = EX_MemRead && (w_rs1_hit || w_rs2_hit || w_rs3_hit);

    hazard_fpu_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (C_RUN_LOAD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic and raw FPU sequencing controls.
    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_dec    = 1'b0;
        w_fsm_start  = 1'b0;
        w_fsm_hold   = 1'b0;
        w_fsm_busy   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (EX_fpu_multi) begin
                    w_fsm_start  = 1'b1;
                    w_fsm_hold   = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_next_state = C_HAS_RUN ? ST_FPU_RUN : ST_FPU_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FPU_RUN: begin
                w_fsm_hold = 1'b1;
                w_fsm_busy = 1'b1;
                w_tmr_dec  = 1'b1;
                if (w_tmr_zero) begin
                    w_next_state = ST_FPU_DONE;
                end else begin
                    w_next_state = ST_FPU_RUN;
                end
            end
            ST_FPU_DONE: begin
                // The finishing op is still in EX this cycle, so EX_fpu_multi is not a new request.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output priority: reset, FPU hold, branch flush, load-use stall, normal flow.
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        EX_hold      = 1'b0;
        fpu_start    = 1'b0;
        fpu_busy     = 1'b0;
        if (reset) begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
        end else if (w_fsm_hold) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_hold     = 1'b1;
            fpu_start   = w_fsm_start;
            fpu_busy    = w_fsm_busy;
        end else if (branch_taken) begin
            PC_write     = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (w_load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else begin
            PC_write    = 1'b1;
            IF_ID_write = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: two instances (FPU_LAT=4 and FPU_LAT=2) on shared
// stimulus, compared against a cycles-since-launch reference model plus directed expectations.
module tb_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] ID_Rs1, ID_Rs2, ID_frs3, EX_Rd;
    logic       ID_useRs1, ID_useRs2, ID_useRs3, ID_fpRs1, ID_fpRs2;
    logic       EX_MemRead, EX_RegWrite, EX_f_RegWrite, EX_fpu_multi, branch_taken;

    // Output vectors: {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, EX_hold, fpu_start, fpu_busy}
    wire [6:0] a4;
    wire [6:0] a2;

    int n_checks = 0;
    int n_pass   = 0;
    int ph4      = 0;   // cycles since the current FPU op was launched, 0 = no op in progress
    int ph2      = 0;
    logic [6:0] e4, e2;

    hazard_controller #(.FPU_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_frs3(ID_frs3),
        .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2), .ID_useRs3(ID_useRs3),
        .ID_fpRs1(ID_fpRs1), .ID_fpRs2(ID_fpRs2),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_f_RegWrite(EX_f_RegWrite),
        .EX_Rd(EX_Rd), .EX_fpu_multi(EX_fpu_multi), .branch_taken(branch_taken),
        .PC_write(a4[6]), .IF_ID_write(a4[5]), .ID_EX_bubble(a4[4]), .IF_ID_flush(a4[3]),
        .EX_hold(a4[2]), .fpu_start(a4[1]), .fpu_busy(a4[0])
    );

    hazard_controller #(.FPU_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_frs3(ID_frs3),
        .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2), .ID_useRs3(ID_useRs3),
        .ID_fpRs1(ID_fpRs1), .ID_fpRs2(ID_fpRs2),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_f_RegWrite(EX_f_RegWrite),
        .EX_Rd(EX_Rd), .EX_fpu_multi(EX_fpu_multi), .branch_taken(branch_taken),
        .PC_write(a2[6]), .IF_ID_write(a2[5]), .ID_EX_bubble(a2[4]), .IF_ID_flush(a2[3]),
        .EX_hold(a2[2]), .fpu_start(a2[1]), .fpu_busy(a2[0])
    );

    // ---------------- reference model ----------------
    function automatic logic model_load_use();
        logic [4:0] src [3];
        logic       used [3];
        logic       fp [3];
        logic       hit;
        src  = '{ID_Rs1, ID_Rs2, ID_frs3};
        used = '{ID_useRs1, ID_useRs2, ID_useRs3};
        fp   = '{ID_fpRs1, ID_fpRs2, 1'b1};
        hit  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (EX_MemRead && used[k] && (src[k] == EX_Rd)) begin
                if (fp[k]) hit = hit | EX_f_RegWrite;
                else       hit = hit | (EX_RegWrite && (EX_Rd != 5'd0));
            end
        end
        return hit;
    endfunction

    function automatic logic [6:0] model_out(input int ph, input int lat);
        logic hold, start, busy;
        hold = 1'b0; start = 1'b0; busy = 1'b0;
        if (reset) return 7'b1100000;
        if (ph == 0) begin
            if (EX_fpu_multi) begin start = 1'b1; hold = 1'b1; end
        end else if (ph <= lat - 2) begin
            hold = 1'b1; busy = 1'b1;
        end
        if (hold)              return {4'b0000, 1'b1, start, busy};
        if (branch_taken)      return 7'b1111000;
        if (model_load_use())  return 7'b0010000;
        return 7'b1100000;
    endfunction

    function automatic int model_next(input int ph, input int lat);
        if (reset)          return 0;
        if (ph == 0)        return EX_fpu_multi ? 1 : 0;
        if (ph >= lat - 1)  return 0;
        return ph + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        ph4 = model_next(ph4, 4);
        ph2 = model_next(ph2, 2);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 1'b0;
        ID_Rs1 = 5'd0; ID_Rs2 = 5'd0; ID_frs3 = 5'd0; EX_Rd = 5'd0;
        ID_useRs1 = 1'b0; ID_useRs2 = 1'b0; ID_useRs3 = 1'b0;
        ID_fpRs1 = 1'b0; ID_fpRs2 = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_f_RegWrite = 1'b0;
        EX_fpu_multi = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        EX_fpu_multi = 1'b1;
        branch_taken = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (a4 !== 7'b1100000) $display("FAIL reset_out4 got=%b exp=%b", a4, 7'b1100000);
        else n_pass++;
        n_checks++;
        if (a2 !== 7'b1100000) $display("FAIL reset_out2 got=%b exp=%b", a2, 7'b1100000);
        else n_pass++;
        tick();
        idle(1);
        @(negedge clk);
        n_checks++;
        if (a4 !== 7'b1100000) $display("FAIL post_reset_idle got=%b exp=%b", a4, 7'b1100000);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [6:0] exp;
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            exp = 7'b1100000;
            case (k)
                0: begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5; ID_useRs2 = 1'b1; exp = 7'b0010000; end
                1: begin EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5; ID_useRs2 = 1'b1; end
                2: begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; ID_useRs2 = 1'b1; end
                3: begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs2 = 5'd5; ID_useRs2 = 1'b1; ID_fpRs2 = 1'b1; end
                4: begin EX_MemRead = 1'b1; EX_f_RegWrite = 1'b1; ID_useRs2 = 1'b1; ID_fpRs2 = 1'b1; exp = 7'b0010000; end
                5: begin EX_MemRead = 1'b1; EX_f_RegWrite = 1'b1; EX_Rd = 5'd9; ID_frs3 = 5'd9; ID_useRs3 = 1'b1; exp = 7'b0010000; end
                6: begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd7; ID_Rs1 = 5'd7; end
                7: begin EX_MemRead = 1'b1; EX_f_RegWrite = 1'b1; EX_Rd = 5'd7; ID_Rs1 = 5'd7; ID_useRs1 = 1'b1; end
                default: exp = 7'b1100000;
            endcase
            @(negedge clk);
            n_checks++;
            if (a4 !== exp) $display("FAIL load_use4 case=%0d got=%b exp=%b", k, a4, exp);
            else n_pass++;
            n_checks++;
            if (a2 !== exp) $display("FAIL load_use2 case=%0d got=%b exp=%b", k, a2, exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_fpu_lat4();
        logic [3:0] hold_p  = 4'b0111;   // bit i = cycle i
        logic [3:0] start_p = 4'b0001;
        logic [3:0] busy_p  = 4'b0110;
        logic [6:0] exp;
        idle(6);
        for (int i = 0; i < 4; i++) begin
            EX_fpu_multi = (i < 3) ? 1'b1 : 1'b0;
            exp = {~hold_p[i], ~hold_p[i], 2'b00, hold_p[i], start_p[i], busy_p[i]};
            @(negedge clk);
            n_checks++;
            if (a4 !== exp) $display("FAIL fpu_lat4 cyc=%0d got=%b exp=%b", i, a4, exp);
            else n_pass++;
            e2 = model_out(ph2, 2);
            n_checks++;
            if (a2 !== e2) $display("FAIL fpu_lat4_side2 cyc=%0d got=%b exp=%b", i, a2, e2);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_fpu_lat2();
        logic [6:0] exp;
        idle(6);
        for (int i = 0; i < 3; i++) begin
            EX_fpu_multi = (i < 2) ? 1'b1 : 1'b0;
            exp = (i == 0) ? 7'b0000110 : 7'b1100000;
            @(negedge clk);
            n_checks++;
            if (a2 !== exp) $display("FAIL fpu_lat2 cyc=%0d got=%b exp=%b", i, a2, exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_branch();
        idle(6);
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3; ID_useRs1 = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a4 !== 7'b1111000) $display("FAIL branch_over_lu got=%b exp=%b", a4, 7'b1111000);
        else n_pass++;
        tick();
        clear_inputs();
        EX_fpu_multi = 1'b1;
        tick();
        branch_taken = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a4 !== 7'b0000101) $display("FAIL branch_in_run got=%b exp=%b", a4, 7'b0000101);
        else n_pass++;
        e2 = model_out(ph2, 2);
        n_checks++;
        if (a2 !== e2) $display("FAIL branch_in_done2 got=%b exp=%b", a2, e2);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_fpu();
        logic [6:0] exp [7];
        exp = '{7'b0000110, 7'b0000101, 7'b1100000, 7'b0000110, 7'b0000101, 7'b0000101, 7'b1100000};
        idle(6);
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            EX_fpu_multi = (i != 6) ? 1'b1 : 1'b0;
            reset = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            n_checks++;
            if (a4 !== exp[i]) $display("FAIL reset_mid4 cyc=%0d got=%b exp=%b", i, a4, exp[i]);
            else n_pass++;
            e2 = model_out(ph2, 2);
            n_checks++;
            if (a2 !== e2) $display("FAIL reset_mid2 cyc=%0d got=%b exp=%b", i, a2, e2);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] x4, x2;
        idle(6);
        EX_fpu_multi = 1'b1;
        for (int i = 0; i < 12; i++) begin
            x4 = {((i % 4) == 3) ? 2'b11 : 2'b00, 2'b00, ((i % 4) != 3), ((i % 4) == 0), ((i % 4) == 1) || ((i % 4) == 2)};
            x2 = {((i % 2) == 1) ? 2'b11 : 2'b00, 2'b00, ((i % 2) == 0), ((i % 2) == 0), 1'b0};
            @(negedge clk);
            n_checks++;
            if (a4 !== x4) $display("FAIL b2b_lat4 cyc=%0d got=%b exp=%b", i, a4, x4);
            else n_pass++;
            n_checks++;
            if (a2 !== x2) $display("FAIL b2b_lat2 cyc=%0d got=%b exp=%b", i, a2, x2);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            ID_Rs1        = 5'($urandom_range(0, 3));
            ID_Rs2        = 5'($urandom_range(0, 3));
            ID_frs3       = 5'($urandom_range(0, 3));
            EX_Rd         = 5'($urandom_range(0, 3));
            ID_useRs1     = 1'($urandom_range(0, 1));
            ID_useRs2     = 1'($urandom_range(0, 1));
            ID_useRs3     = 1'($urandom_range(0, 1));
            ID_fpRs1      = 1'($urandom_range(0, 1));
            ID_fpRs2      = 1'($urandom_range(0, 1));
            EX_MemRead    = 1'($urandom_range(0, 1));
            EX_RegWrite   = 1'($urandom_range(0, 1));
            EX_f_RegWrite = 1'($urandom_range(0, 1));
            EX_fpu_multi  = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            e4 = model_out(ph4, 4);
            e2 = model_out(ph2, 2);
            n_checks++;
            if (a4 !== e4) $display("FAIL random4 cyc=%0d got=%b exp=%b", i, a4, e4);
            else n_pass++;
            n_checks++;
            if (a2 !== e2) $display("FAIL random2 cyc=%0d got=%b exp=%b", i, a2, e2);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fpu_lat4();
        test_fpu_lat2();
        test_branch();
        test_reset_mid_fpu();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter FPU_LAT, default 4: total EX-stage cycles for a multi-cycle FPU op; legal range 2..16.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ID_Rs1, ID_Rs2, ID_frs3  input  5 each  source register indices of the instruction in ID.
REQ-006 ID_useRs1, ID_useRs2, ID_useRs3  input  1 each  the corresponding source is read.
REQ-007 ID_fpRs1, ID_fpRs2  input  1 each  source comes from the FP register file (rs3 is always FP).
REQ-008 EX_MemRead, EX_RegWrite, EX_f_RegWrite  input  1 each  controls of the instruction in EX.
REQ-009 EX_Rd  input  5  destination of the instruction in EX.
REQ-010 EX_fpu_multi  input  1  EX holds a multi-cycle FPU op.
REQ-011 branch_taken  input  1  taken branch or jump resolved in EX.
REQ-012 PC_write, IF_ID_write  output  1 each  enables for PC and the IF/ID register.
REQ-013 ID_EX_bubble, IF_ID_flush  output  1 each  zero the ID/EX controls; clear IF/ID.
REQ-014 EX_hold  output  1  freeze the ID/EX and EX/MEM registers and inject a bubble into MEM.
REQ-015 fpu_start  output  1  one-cycle FPU launch pulse.
REQ-016 fpu_busy  output  1  FPU sequence in progress.

Function
REQ-017 SHALL implement an FSM with states IDLE, FPU_RUN and FPU_DONE, and a 4-bit down-counter.
REQ-018 In IDLE with EX_fpu_multi=1, SHALL assert fpu_start=1 and EX_hold=1 for that cycle.
REQ-019 From that IDLE cycle, SHALL go to FPU_RUN with the counter loaded to FPU_LAT-3 when FPU_LAT>2, otherwise directly to FPU_DONE.
REQ-020 In FPU_RUN, SHALL assert EX_hold=1 and fpu_busy=1, and decrement the counter.
REQ-021 In FPU_RUN, SHALL move to FPU_DONE when the counter equals 0.
REQ-022 In FPU_DONE, SHALL assert EX_hold=0 and fpu_busy=0, ignore EX_fpu_multi, and return to IDLE next cycle.
REQ-023 EX occupancy of an FPU op SHALL be exactly FPU_LAT cycles.
REQ-024 Whenever EX_hold=1, SHALL also drive PC_write=0 and IF_ID_write=0.
REQ-025 Load-use hazard SHALL be detected when EX_MemRead=1 and a used ID source matches EX_Rd in the same register file.
REQ-026 The integer-file match SHALL require EX_RegWrite=1 and EX_Rd≠0.
REQ-027 The FP-file match SHALL require EX_f_RegWrite=1; f0 is a valid match.
REQ-028 On a load-use hazard, SHALL drive PC_write=0, IF_ID_write=0 and ID_EX_bubble=1 for exactly one cycle; the hazard clears when the load leaves EX.
REQ-029 On branch_taken=1 with EX_hold=0, SHALL drive IF_ID_flush=1, ID_EX_bubble=1 and PC_write=1.
REQ-030 Priority SHALL be: EX_hold (branch_taken and load-use ignored) > branch flush (load-use stall suppressed) > load-use stall.
REQ-031 With no event, SHALL drive PC_write=1, IF_ID_write=1 and all other outputs 0.
REQ-032 All outputs SHALL be combinational from the current state and inputs, with no added latency.

Reset
REQ-033 reset SHALL move the FSM to IDLE and clear the counter on the next clock edge, including mid-FPU-sequence.
REQ-034 While reset=1, outputs SHALL be PC_write=1, IF_ID_write=1 and all others 0.
REQ-035 The first post-reset cycle SHALL evaluate inputs as IDLE.

Structure
REQ-036 The FSM state encoding and the FPU_LAT default SHALL live in the shared pipeline package, reused by the forwarding and FPU blocks.
REQ-037 The down-counter SHALL be one sub-module, hazard_fpu_timer, with load, decrement and zero-flag.
REQ-038 Hazard comparators SHALL remain inline in hazard_controller.

Verification
REQ-039 Load-use: EX_MemRead=1, EX_RegWrite=1, EX_Rd=5, ID_Rs2=5, ID_useRs2=1 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_bubble=1, then normal.
REQ-040 Same as REQ-039 but EX_Rd=0, or ID_fpRs2=1 with EX_f_RegWrite=0 -> no stall.
REQ-041 FPU op, FPU_LAT=4: fpu_start high in cycle 0 only; EX_hold high in cycles 0-2; fpu_busy high in cycles 1-2; release in cycle 3. Repeat with FPU_LAT=2: EX_hold high in cycle 0 only.
REQ-042 branch_taken together with a load-use hazard -> IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; branch_taken during FPU_RUN -> ignored.
REQ-043 reset in the second FPU_RUN cycle -> outputs at reset values; IDLE after the edge; a new EX_fpu_multi restarts the full FPU_LAT sequence.
REQ-044 Back-to-back FPU ops with EX_fpu_multi held across FPU_DONE -> no restart in FPU_DONE; a new fpu_start in the following IDLE cycle.
